// File: rtl/shr_arbiter.sv
// Round-robin arbiter sharing one right shifter among NREQ requesters.
// Optional SHR_ARB_ARITH_EN adds a per-requester arith select for sign-filled shifts.
module shr_arbiter #(
    parameter int DATAWIDTH = 8,
    parameter int NREQ      = 4,
    parameter int IDW       = 2
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DATAWIDTH-1:0] a_bus,
    input  logic [NREQ*DATAWIDTH-1:0] sh_bus,
`ifdef SHR_ARB_ARITH_EN
    input  logic [NREQ-1:0]           arith,
`endif
    output logic [NREQ-1:0]           gnt,
    output logic [DATAWIDTH-1:0]      d,
    output logic                      valid,
    output logic [IDW-1:0]            valid_id,
    output logic                      busy
);

    // state | meaning
    // IDLE  | waiting for any req; arbitrates and captures operands
    // EXEC  | grant pulse high; shift result registered into d
    // RESP  | valid pulse high; returns to IDLE
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                state;
    logic [IDW-1:0]        last;
    logic [IDW-1:0]        id;
    logic [DATAWIDTH-1:0]  op_a;
    logic [DATAWIDTH-1:0]  op_sh;
    logic [IDW-1:0]        sel;
    logic [DATAWIDTH-1:0]  shr_res;
`ifdef SHR_ARB_ARITH_EN
    logic                  op_ar;
`endif

    // Search starts just after the last winner and wraps, giving round-robin priority.
    always_comb begin
        logic found;
        int   idx;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(last) + i) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = IDW'(idx);
            end
        end
    end

    // Shift counts at or beyond DATAWIDTH fall out naturally as zero (or sign fill).
    always_comb begin
`ifdef SHR_ARB_ARITH_EN
        if (op_ar)
            shr_res = $unsigned($signed(op_a) >>> op_sh);
        else
            shr_res = op_a >> op_sh;
`else
        shr_res = op_a >> op_sh;
`endif
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state    <= IDLE;
            gnt      <= '0;
            d        <= '0;
            valid    <= 1'b0;
            valid_id <= '0;
            busy     <= 1'b0;
            last     <= IDW'(NREQ - 1);
            id       <= '0;
            op_a     <= '0;
            op_sh    <= '0;
`ifdef SHR_ARB_ARITH_EN
            op_ar    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt      <= '0;
                        gnt[sel] <= 1'b1;
                        op_a     <= a_bus[int'(sel)*DATAWIDTH +: DATAWIDTH];
                        op_sh    <= sh_bus[int'(sel)*DATAWIDTH +: DATAWIDTH];
`ifdef SHR_ARB_ARITH_EN
                        op_ar    <= arith[sel];
`endif
                        id       <= sel;
                        last     <= sel;
                        busy     <= 1'b1;
                        state    <= EXEC;
                    end else begin
                        gnt <= '0;
                    end
                end
                EXEC: begin
                    gnt      <= '0;
                    d        <= shr_res;
                    valid    <= 1'b1;
                    valid_id <= id;
                    state    <= RESP;
                end
                RESP: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shr_arbiter.sv
// Directed bench for shr_arbiter (DATAWIDTH=8, NREQ=4); covers arith mode when SHR_ARB_ARITH_EN is defined.
module tb_shr_arbiter;

    logic        Clk;
    logic        Rst;
    logic [3:0]  req;
    logic [31:0] a_bus;
    logic [31:0] sh_bus;
`ifdef SHR_ARB_ARITH_EN
    logic [3:0]  arith;
`endif
    logic [3:0]  gnt;
    logic [7:0]  d;
    logic        valid;
    logic [1:0]  valid_id;
    logic        busy;

    int n_cmp;
    int n_err;

    shr_arbiter #(.DATAWIDTH(8), .NREQ(4), .IDW(2)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .req      (req),
        .a_bus    (a_bus),
        .sh_bus   (sh_bus),
`ifdef SHR_ARB_ARITH_EN
        .arith    (arith),
`endif
        .gnt      (gnt),
        .d        (d),
        .valid    (valid),
        .valid_id (valid_id),
        .busy     (busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] sh);
        a_bus[i*8 +: 8]  = a;
        sh_bus[i*8 +: 8] = sh;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b0;
        req = 4'b0000;
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    task automatic wait_gnt(input string tag, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge Clk);
            #1;
            if (gnt != 4'b0000) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_val({tag, "_gnt_timeout"}, 32'd0, 32'd1);
    endtask

    // One full grant/exec/response transaction with all outputs checked per cycle.
    task automatic run_op(input string tag, input logic [3:0] r, input bit drop,
                          input logic [3:0] exp_gnt, input logic [1:0] exp_id,
                          input logic [7:0] exp_d);
        bit ok;
        req = r;
        wait_gnt(tag, ok);
        if (!ok) return;
        check_val({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
        check_val({tag, "_busy_g"}, 32'(busy), 32'd1);
        check_val({tag, "_valid_g"}, 32'(valid), 32'd0);
        if (drop) req = 4'b0000;
        @(posedge Clk);
        #1;
        check_val({tag, "_valid"}, 32'(valid), 32'd1);
        check_val({tag, "_d"}, 32'(d), 32'(exp_d));
        check_val({tag, "_id"}, 32'(valid_id), 32'(exp_id));
        check_val({tag, "_gnt_off"}, 32'(gnt), 32'd0);
        check_val({tag, "_busy_v"}, 32'(busy), 32'd1);
        @(posedge Clk);
        #1;
        check_val({tag, "_busy_end"}, 32'(busy), 32'd0);
        check_val({tag, "_valid_end"}, 32'(valid), 32'd0);
    endtask

    initial begin
        bit ok;
        n_cmp  = 0;
        n_err  = 0;
        Rst    = 1'b0;
        req    = 4'b0000;
        a_bus  = '0;
        sh_bus = '0;
`ifdef SHR_ARB_ARITH_EN
        arith  = 4'b0000;
`endif
        #2;
        check_val("rst_gnt", 32'(gnt), 32'd0);
        check_val("rst_d", 32'(d), 32'd0);
        check_val("rst_valid", 32'(valid), 32'd0);
        check_val("rst_id", 32'(valid_id), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        @(negedge Clk);
        Rst = 1'b1;

        // Basic single op
        set_op(0, 8'hB4, 8'd2);
        run_op("t1", 4'b0001, 1'b1, 4'b0001, 2'd0, 8'h2D);

        // Shift amount boundaries
        set_op(0, 8'hA5, 8'd0);
        run_op("t3_sh0", 4'b0001, 1'b1, 4'b0001, 2'd0, 8'hA5);
        set_op(0, 8'hA5, 8'd7);
        run_op("t3_sh7", 4'b0001, 1'b1, 4'b0001, 2'd0, 8'h01);
        set_op(0, 8'hA5, 8'd8);
        run_op("t3_sh8", 4'b0001, 1'b1, 4'b0001, 2'd0, 8'h00);
        set_op(0, 8'hA5, 8'hFF);
        run_op("t3_shff", 4'b0001, 1'b1, 4'b0001, 2'd0, 8'h00);

        // Fairness rotation with all requests held
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, 8'hF0, 8'(i));
        run_op("t2_0", 4'b1111, 1'b0, 4'b0001, 2'd0, 8'hF0);
        run_op("t2_1", 4'b1111, 1'b0, 4'b0010, 2'd1, 8'h78);
        run_op("t2_2", 4'b1111, 1'b0, 4'b0100, 2'd2, 8'h3C);
        run_op("t2_3", 4'b1111, 1'b0, 4'b1000, 2'd3, 8'h1E);
        run_op("t2_4", 4'b1111, 1'b1, 4'b0001, 2'd0, 8'hF0);

        // Async reset while in EXEC; d is 0xF0 beforehand
        req = 4'b0100;
        wait_gnt("t4", ok);
        req = 4'b0000;
        if (ok) begin
            check_val("t4_gnt_pre", 32'(gnt), 32'b0100);
            #2;
            Rst = 1'b0;
            #1;
            check_val("t4_gnt", 32'(gnt), 32'd0);
            check_val("t4_valid", 32'(valid), 32'd0);
            check_val("t4_busy", 32'(busy), 32'd0);
            check_val("t4_d", 32'(d), 32'd0);
            @(negedge Clk);
            Rst = 1'b1;
            for (int c = 0; c < 3; c++) begin
                @(posedge Clk);
                #1;
                check_val("t4_no_valid", 32'(valid), 32'd0);
            end
        end
        set_op(1, 8'h3C, 8'd1);
        set_op(3, 8'hFF, 8'd4);
        run_op("t4_after", 4'b1010, 1'b1, 4'b0010, 2'd1, 8'h1E);

        // Wraparound: last=2, then req=0101 -> 0 then 2
        set_op(0, 8'h81, 8'd1);
        set_op(2, 8'h40, 8'd3);
        run_op("t5_a", 4'b0100, 1'b1, 4'b0100, 2'd2, 8'h08);
        run_op("t5_b", 4'b0101, 1'b0, 4'b0001, 2'd0, 8'h40);
        run_op("t5_c", 4'b0101, 1'b1, 4'b0100, 2'd2, 8'h08);

`ifdef SHR_ARB_ARITH_EN
        arith = 4'b0001;
        set_op(0, 8'h80, 8'd3);
        run_op("t6_ar3", 4'b0001, 1'b1, 4'b0001, 2'd0, 8'hF0);
        set_op(0, 8'h80, 8'd9);
        run_op("t6_ar9", 4'b0001, 1'b1, 4'b0001, 2'd0, 8'hFF);
        arith = 4'b0000;
        set_op(0, 8'h80, 8'd3);
        run_op("t6_lg3", 4'b0001, 1'b1, 4'b0001, 2'd0, 8'h10);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
